// File: rtl/data_memory_pkg.sv
// Shared types and defaults for the parameterised data memory and its clear sequencer.
package data_memory_pkg;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 4;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

    typedef enum logic {
        WRITE_FIRST = 1'b0,
        READ_FIRST  = 1'b1
    } read_mode_e;
endpackage

// File: rtl/mem_clear_sequencer.sv
// CLEAR/READY machine: sweeps every word to zero after reset or on a clear request,
// one word per cycle, and reports readiness once the sweep finishes.
module mem_clear_sequencer
    import data_memory_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    output logic              ready_o,
    output logic [ADDR_W-1:0] clr_addr_o,
    output logic              clr_we_o
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A clear request during the sweep is ignored; the sweep never restarts mid-way.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            CLEAR: begin
                if (cnt_q == LAST_ADDR) begin
                    state_d = READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            READY: begin
                if (clear_i) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        ready_o    = (state_q == READY);
        clr_we_o   = (state_q == CLEAR);
        clr_addr_o = cnt_q;
    end
endmodule

// File: rtl/param_data_memory.sv
// Word-addressed memory with byte-enable writes, 1-cycle registered read data and a
// hardware clear sweep; READ_MODE selects the word returned on a write.
module param_data_memory
    import data_memory_pkg::*;
#(
    parameter int         DATA_W    = DEF_DATA_W,
    parameter int         ADDR_W    = DEF_ADDR_W,
    parameter read_mode_e READ_MODE = WRITE_FIRST
) (
    input  logic                CLOCK_50,
    input  logic                RESET_N,
    input  logic                CNTRL_req,
    input  logic                CNTRL_write_en,
    input  logic [DATA_W/8-1:0] CNTRL_byte_en,
    input  logic [ADDR_W-1:0]   Mem_addr,
    input  logic [DATA_W-1:0]   RF_Rd_data,
    input  logic                CNTRL_clear,
    output logic                Mem_ready,
    output logic [DATA_W-1:0]   Mem_data,
    output logic                Mem_valid
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NB    = DATA_W / 8;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;

    logic              ready;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              accept;
    logic [DATA_W-1:0] old_word;
    logic [DATA_W-1:0] merged;

    mem_clear_sequencer #(
        .ADDR_W (ADDR_W)
    ) u_seq (
        .clk_i      (CLOCK_50),
        .rst_ni     (RESET_N),
        .clear_i    (CNTRL_clear),
        .ready_o    (ready),
        .clr_addr_o (clr_addr),
        .clr_we_o   (clr_we)
    );

    // A clear on the same edge as a request wins and drops the request.
    assign accept   = CNTRL_req & ready & ~CNTRL_clear;
    assign old_word = mem_q[Mem_addr];

    always_comb begin
        merged = old_word;
        for (int k = 0; k < NB; k++) begin
            if (CNTRL_byte_en[k]) merged[8*k +: 8] = RF_Rd_data[8*k +: 8];
        end
    end

    // Sweep writes and accepted accesses are exclusive since acceptance needs READY.
    always_ff @(posedge CLOCK_50) begin
        if (clr_we) begin
            mem_q[clr_addr] <= '0;
        end else if (accept && CNTRL_write_en) begin
            mem_q[Mem_addr] <= merged;
        end
    end

    always_comb begin
        data_d  = data_q;
        valid_d = 1'b0;
        if (accept) begin
            valid_d = 1'b1;
            if (CNTRL_write_en && (READ_MODE == WRITE_FIRST)) data_d = merged;
            else                                              data_d = old_word;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign Mem_ready = ready;
    assign Mem_data  = data_q;
    assign Mem_valid = valid_q;
endmodule
